// File: rtl/noise_scan_ctrl_pkg.sv
// noise_scan_pkg: shared defaults and the per-channel filter state record
// used by the noise_scan_ctrl scan scheduler and its filter step.
// The cnt field is sized for DEF_CONFIRM, so any CONFIRM override on the
// top must still fit in CNT_W bits.
package noise_scan_pkg;

  localparam int DEF_N_CH     = 8;
  localparam int DEF_PRESCALE = 1000;
  localparam int DEF_CONFIRM  = 2;

  localparam int CNT_W = $clog2(DEF_CONFIRM + 1);

  typedef struct packed {
    logic             lvl;
    logic [CNT_W-1:0] cnt;
  } chan_state_t;

endpackage

// File: rtl/noise_scan_ctrl_if.sv
// noise_scan_ctrl_if: raw inputs and enables going into the scan scheduler,
// debounced levels, edge events and the end-of-scan strobe coming out.
// The master side drives inputs; the slave side is noise_scan_ctrl.
interface noise_scan_ctrl_if import noise_scan_pkg::*; #(
  parameter int N_CH = DEF_N_CH
) ();

  logic [N_CH-1:0] d_in;
  logic [N_CH-1:0] en_mask;
  logic [N_CH-1:0] q_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            scan_done;

  modport master (
    output d_in,
    output en_mask,
    input  q_out,
    input  rise,
    input  fall,
    input  scan_done
  );

  modport slave (
    input  d_in,
    input  en_mask,
    output q_out,
    output rise,
    output fall,
    output scan_done
  );

endinterface

// File: rtl/noise_scan_ctrl_filter_step.sv
// noise_filter_step: combinational next-state for one channel of the shared
// noise filter. A new level is only accepted after CONFIRM consecutive
// visits that disagree with the current level; any agreeing or masked
// visit throws the partial count away.
module noise_filter_step import noise_scan_pkg::*; #(
  parameter int CONFIRM = DEF_CONFIRM
) (
  input  logic        d,
  input  logic        en,
  input  chan_state_t cur,
  output chan_state_t nxt,
  output logic        evt_rise,
  output logic        evt_fall
);

  logic [CNT_W:0] cntInc;

  assign cntInc = {1'b0, cur.cnt} + (CNT_W + 1)'(1);

  // Decide whether this visit clears, advances or completes the disagreement run
  always_comb begin
    nxt      = cur;
    evt_rise = 1'b0;
    evt_fall = 1'b0;
    if (!en) begin
      nxt.cnt = '0;
    end else if (d == cur.lvl) begin
      nxt.cnt = '0;
    end else if (cntInc == (CNT_W + 1)'(CONFIRM)) begin
      nxt.lvl  = d;
      nxt.cnt  = '0;
      evt_rise = d;
      evt_fall = ~d;
    end else begin
      nxt.cnt = cntInc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/noise_scan_ctrl.sv
// noise_scan_ctrl: round-robin scan scheduler sharing one noise filter
// among N_CH asynchronous inputs. A prescaler produces one tick every
// PRESCALE cycles; each tick filters the channel under the pointer.
// Optional feature macro: NOISE_SCAN_EVENT_EN builds the rise/fall event
// registers; without it rise and fall are tied to 0.
module noise_scan_ctrl import noise_scan_pkg::*; #(
  parameter int N_CH     = DEF_N_CH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int CONFIRM  = DEF_CONFIRM
) (
  input  logic              clk,
  input  logic              reset,
  noise_scan_ctrl_if.slave  bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int CW = $clog2(N_CH);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

  logic [N_CH-1:0] syncMeta_q;
  logic [N_CH-1:0] dSync_q;
  logic [PW-1:0]   pcnt_q;
  logic [CW-1:0]   chPtr_q;
  logic            scanDone_q;
  logic            tick;

  chan_state_t chanState_q [N_CH];
  chan_state_t chanState_d [N_CH];
  chan_state_t curState;
  chan_state_t stepState;
  logic        stepRise;
  logic        stepFall;
  logic [N_CH-1:0] levels;

  // Two-flop synchronizer bringing the raw inputs into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      syncMeta_q <= '0;
      dSync_q    <= '0;
    end else begin
      syncMeta_q <= bus.d_in;
      dSync_q    <= syncMeta_q;
    end
  end

  assign tick = (pcnt_q == PCNT_LAST);

  // Prescaler and channel pointer; the pointer moves one channel per tick
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q     <= '0;
      chPtr_q    <= '0;
      scanDone_q <= 1'b0;
    end else begin
      pcnt_q     <= tick ? '0 : pcnt_q + PW'(1);
      scanDone_q <= tick && (chPtr_q == CH_LAST);
      if (tick) begin
        chPtr_q <= (chPtr_q == CH_LAST) ? '0 : chPtr_q + CW'(1);
      end
    end
  end

  assign curState = chanState_q[chPtr_q];

  noise_filter_step #(
    .CONFIRM (CONFIRM)
  ) u_step (
    .d        (dSync_q[chPtr_q]),
    .en       (bus.en_mask[chPtr_q]),
    .cur      (curState),
    .nxt      (stepState),
    .evt_rise (stepRise),
    .evt_fall (stepFall)
  );

  // Only the channel under the pointer picks up the filter result on a tick
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      chanState_d[i] = chanState_q[i];
    end
    if (tick) begin
      chanState_d[chPtr_q] = stepState;
    end
  end

  // Per-channel filter state array
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        chanState_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        chanState_q[i] <= chanState_d[i];
      end
    end
  end

  // Debounced levels come straight from the registered lvl bits
  always_comb begin
    levels = '0;
    for (int i = 0; i < N_CH; i++) begin
      levels[i] = chanState_q[i].lvl;
    end
  end

  assign bus.q_out     = levels;
  assign bus.scan_done = scanDone_q;

`ifdef NOISE_SCAN_EVENT_EN
  logic [N_CH-1:0] rise_q;
  logic [N_CH-1:0] fall_q;
  logic [N_CH-1:0] rise_d;
  logic [N_CH-1:0] fall_d;

  // Place this tick's accepted edge on the serviced channel's bit
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    if (tick) begin
      rise_d[chPtr_q] = stepRise;
      fall_d[chPtr_q] = stepFall;
    end
  end

  // Event registers, so each edge is visible for exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`else
  logic unusedEvt;

  assign unusedEvt = stepRise | stepFall;
  assign bus.rise  = '0;
  assign bus.fall  = '0;
`endif

endmodule
